// File: rtl/cpu_types_pkg.sv
`timescale 1ns/1ps
// Shared CPU types used by the L1 data cache controller.
//   dcachef_t      : dmemaddr split into tag / index / block offset / byte offset
//   dcache_state_t : controller FSM states
//   HIT_CNT_ADDR   : memory word that receives the final hit counter on halt
package cpu_types_pkg;

  localparam int          DC_IDX_W     = 3;
  localparam logic [31:0] HIT_CNT_ADDR = 32'h0000_3100;

  typedef struct packed {
    logic [25:0]         tag;
    logic [DC_IDX_W-1:0] idx;
    logic                blkoff;
    logic [1:0]          bytoff;
  } dcachef_t;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FL_CHK, FL_WB0, FL_WB1, FL_NEXT, CNT, DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_ctrl.sv
`timescale 1ns/1ps
// Direct-mapped L1 data cache sequencer (8 sets x 2 words, tag/data array is
// external). Resolves misses with an optional dirty writeback followed by a
// two-word fill, flushes dirty frames on halt, then stores the hit counter.
//
// Ports
//   CLK, RST          clock / synchronous active-high reset
//   halt              CPU halted, start flush
//   dmemREN/WEN/addr  CPU data request
//   dhit, flushed     request satisfied this cycle / flush complete (sticky)
//   arr_*  (in)       frame status and word read from the array at arr_indx/arr_off
//   arr_*  (out)      array address and write strobes
//   dREN/dWEN/daddr/dstore/dwait   memory port
module dcache_ctrl
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  output logic        dhit,
  output logic        flushed,
  input  logic        arr_hit,
  input  logic        arr_valid,
  input  logic        arr_dirty,
  input  logic [25:0] arr_tag,
  input  logic [31:0] arr_word,
  output logic [2:0]  arr_indx,
  output logic        arr_off,
  output logic        arr_wr_hit,
  output logic        arr_fill_we,
  output logic        arr_set_tag,
  output logic        arr_clean,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait
);

  localparam logic [2:0] LAST_SET = 3'(NSETS - 1);

  dcache_state_t state, nstate;
  logic [2:0]    fcnt, nfcnt;
  logic [31:0]   hit_count, nhit_count;
  dcachef_t      a;
  logic          req;
  logic          flush_st;
  logic [2:0]    idx;
  logic          unused_bytoff;

  assign a             = dcachef_t'(dmemaddr);
  assign unused_bytoff = ^a.bytoff;
  assign req           = dmemREN | dmemWEN;
  assign flush_st      = (state == FL_CHK) || (state == FL_WB0) ||
                         (state == FL_WB1) || (state == FL_NEXT);
  // During a flush the frame walked is the flush counter, not the CPU address.
  assign idx           = flush_st ? fcnt : a.idx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      fcnt      <= '0;
      hit_count <= '0;
    end else begin
      state     <= nstate;
      fcnt      <= nfcnt;
      hit_count <= nhit_count;
    end
  end

  always_comb begin
    nstate      = state;
    nfcnt       = fcnt;
    nhit_count  = hit_count;
    dhit        = 1'b0;
    flushed     = 1'b0;
    arr_indx    = idx;
    arr_off     = a.blkoff;
    arr_wr_hit  = 1'b0;
    arr_fill_we = 1'b0;
    arr_set_tag = 1'b0;
    arr_clean   = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;
    if (RST) begin
      arr_indx = '0;
      arr_off  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // halt wins over a request in the same cycle
          if (halt) begin
            nstate = FL_CHK;
            nfcnt  = '0;
          end else if (req) begin
            if (arr_hit) begin
              dhit       = 1'b1;
              arr_wr_hit = dmemWEN;
              nhit_count = hit_count + 32'd1;
            end else begin
              nhit_count = hit_count - 32'd1;
              nstate     = (arr_valid && arr_dirty) ? WB0 : LD0;
            end
          end
        end
        WB0, WB1, FL_WB0, FL_WB1: begin
          arr_off = (state == WB1) || (state == FL_WB1);
          dWEN    = 1'b1;
          daddr   = {arr_tag, idx, arr_off, 2'b00};
          dstore  = arr_word;
          if (!dwait) begin
            unique case (state)
              WB0:     nstate = WB1;
              WB1:     nstate = LD0;
              FL_WB0:  nstate = FL_WB1;
              default: begin
                arr_clean = 1'b1;
                nstate    = FL_NEXT;
              end
            endcase
          end
        end
        LD0, LD1: begin
          arr_off = (state == LD1);
          dREN    = 1'b1;
          daddr   = {a.tag, idx, arr_off, 2'b00};
          if (!dwait) begin
            arr_fill_we = 1'b1;
            if (state == LD1) begin
              // block complete: install tag so the retry cycle hits
              arr_set_tag = 1'b1;
              nstate      = IDLE;
            end else begin
              nstate = LD1;
            end
          end
        end
        FL_CHK: begin
          arr_off = 1'b0;
          nstate  = (arr_valid && arr_dirty) ? FL_WB0 : FL_NEXT;
        end
        FL_NEXT: begin
          arr_off = 1'b0;
          if (fcnt == LAST_SET) begin
            nstate = CNT;
          end else begin
            nfcnt  = fcnt + 3'd1;
            nstate = FL_CHK;
          end
        end
        CNT: begin
          dWEN   = 1'b1;
          daddr  = HIT_CNT_ADDR;
          dstore = hit_count;
          if (!dwait) nstate = DONE;
        end
        DONE:    flushed = 1'b1;
        default: nstate  = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
// Directed table-driven bench for dcache_ctrl: each row is one clock cycle of
// inputs plus the expected combinational outputs for that cycle.
module tb_dcache_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, halt, dmemREN, dmemWEN, dwait;
  logic [31:0] dmemaddr, arr_word, daddr, dstore;
  logic        arr_hit, arr_valid, arr_dirty;
  logic [25:0] arr_tag;
  logic        dhit, flushed, arr_off, arr_wr_hit, arr_fill_we, arr_set_tag, arr_clean;
  logic        dREN, dWEN;
  logic [2:0]  arr_indx;

  always #5 CLK = ~CLK;

  dcache_ctrl dut (
    .CLK(CLK), .RST(RST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dhit(dhit), .flushed(flushed), .arr_hit(arr_hit),
    .arr_valid(arr_valid), .arr_dirty(arr_dirty), .arr_tag(arr_tag),
    .arr_word(arr_word), .arr_indx(arr_indx), .arr_off(arr_off),
    .arr_wr_hit(arr_wr_hit), .arr_fill_we(arr_fill_we), .arr_set_tag(arr_set_tag),
    .arr_clean(arr_clean), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dwait(dwait)
  );

  typedef struct packed {
    logic rst, halt, ren, wen;
    logic [31:0] addr;
    logic ahit, avalid, adirty;
    logic [25:0] atag;
    logic [31:0] aword;
    logic dwait;
  } in_t;

  typedef struct packed {
    logic dhit, dren, dwen;
    logic [31:0] daddr, dstore;
    logic fill, settag, wrhit, clean, flushed;
    logic [2:0] indx;
    logic off;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic in_t iv(logic rst, logic hlt, logic ren, logic wen, logic [31:0] addr,
                             logic ahit, logic avalid, logic adirty, logic [25:0] atag,
                             logic [31:0] aword, logic dw);
    iv = '{rst, hlt, ren, wen, addr, ahit, avalid, adirty, atag, aword, dw};
  endfunction

  function automatic out_t ov(logic h, logic r, logic w, logic [31:0] da, logic [31:0] ds,
                              logic fi, logic st, logic wh, logic cl, logic fl,
                              logic [2:0] ix, logic of);
    ov = '{h, r, w, da, ds, fi, st, wh, cl, fl, ix, of};
  endfunction

  // input shorthands
  function automatic in_t i_rst(logic dw);
    i_rst = iv(1, 1, 1, 1, 32'h48, 1, 1, 1, 26'h1, 32'hDEAD_BEEF, dw);
  endfunction
  function automatic in_t i_cpu(logic hlt, logic ren, logic wen, logic [31:0] addr,
                                logic ahit, logic v, logic d, logic [25:0] t);
    i_cpu = iv(0, hlt, ren, wen, addr, ahit, v, d, t, 32'h0, 0);
  endfunction
  function automatic in_t i_mem(logic [31:0] addr, logic [25:0] t, logic [31:0] w,
                                logic dw, logic hlt);
    i_mem = iv(0, hlt, 0, 0, addr, 0, 1, 1, t, w, dw);
  endfunction
  function automatic in_t i_fl(logic v, logic d, logic [25:0] t);
    i_fl = iv(0, 1, 0, 0, 32'h48, 0, v, d, t, 32'h0, 0);
  endfunction

  // expectation shorthands
  function automatic out_t o_idle(logic [2:0] ix, logic of);
    o_idle = ov(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, ix, of);
  endfunction
  function automatic out_t o_hit(logic [2:0] ix, logic of, logic wr);
    o_hit = ov(1, 0, 0, 32'h0, 32'h0, 0, 0, wr, 0, 0, ix, of);
  endfunction
  function automatic out_t o_wr(logic [31:0] da, logic [31:0] ds, logic [2:0] ix,
                                logic of, logic cl);
    o_wr = ov(0, 0, 1, da, ds, 0, 0, 0, cl, 0, ix, of);
  endfunction
  function automatic out_t o_rd(logic [31:0] da, logic [2:0] ix, logic of, logic fi, logic st);
    o_rd = ov(0, 1, 0, da, 32'h0, fi, st, 0, 0, 0, ix, of);
  endfunction
  function automatic out_t o_done(logic [2:0] ix, logic of);
    o_done = ov(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1, ix, of);
  endfunction

  task automatic add(input string n, input in_t i, input out_t o);
    tbl.push_back('{n, i, o});
  endtask

  task automatic drive(input in_t i);
    RST       = i.rst;
    halt      = i.halt;
    dmemREN   = i.ren;
    dmemWEN   = i.wen;
    dmemaddr  = i.addr;
    arr_hit   = i.ahit;
    arr_valid = i.avalid;
    arr_dirty = i.adirty;
    arr_tag   = i.atag;
    arr_word  = i.aword;
    dwait     = i.dwait;
  endtask

  task automatic chk(input string n, input int row, input out_t exp);
    out_t got;
    got = '{dhit, dREN, dWEN, daddr, dstore, arr_fill_we, arr_set_tag,
            arr_wr_hit, arr_clean, flushed, arr_indx, arr_off};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (row %0d): got %h expected %h", n, row, got, exp);
    end
  endtask

  task automatic build();
    // reset: every output forced low even with a busy-looking input set
    add("rst0", i_rst(0), '0);
    add("rst1", i_rst(0), '0);
    // cold read miss at 0x48: tag 1, idx 1 -> fill 0x48 / 0x4C, 2 wait cycles each
    add("cold_miss", i_cpu(0, 1, 0, 32'h48, 0, 0, 0, 26'h0), o_idle(1, 0));      // hc=-1
    add("ld0_wait",  i_mem(32'h48, 26'h0, 32'h0, 1, 0), o_rd(32'h48, 1, 0, 0, 0));
    add("ld0_wait",  i_mem(32'h48, 26'h0, 32'h0, 1, 0), o_rd(32'h48, 1, 0, 0, 0));
    add("ld0_done",  i_mem(32'h48, 26'h0, 32'h0, 0, 0), o_rd(32'h48, 1, 0, 1, 0));
    add("ld1_wait",  i_mem(32'h48, 26'h0, 32'h0, 1, 0), o_rd(32'h4C, 1, 1, 0, 0));
    add("ld1_wait",  i_mem(32'h48, 26'h0, 32'h0, 1, 0), o_rd(32'h4C, 1, 1, 0, 0));
    add("ld1_done",  i_mem(32'h48, 26'h0, 32'h0, 0, 0), o_rd(32'h4C, 1, 1, 1, 1));
    add("retry_hit", i_cpu(0, 1, 0, 32'h48, 1, 1, 0, 26'h1), o_hit(1, 0, 0));    // hc=0
    add("quiet",     i_cpu(0, 0, 0, 32'h48, 1, 1, 0, 26'h1), o_idle(1, 0));
    // three read hits
    add("rd_hit_a",  i_cpu(0, 1, 0, 32'h48, 1, 1, 0, 26'h1), o_hit(1, 0, 0));
    add("rd_hit_b",  i_cpu(0, 1, 0, 32'h4C, 1, 1, 0, 26'h1), o_hit(1, 1, 0));
    add("rd_hit_c",  i_cpu(0, 1, 0, 32'h48, 1, 1, 0, 26'h1), o_hit(1, 0, 0));    // hc=3
    // conflict write miss 0x448 (tag 0x11, idx 1) over dirty frame with tag 1
    add("wr_miss",   i_cpu(0, 0, 1, 32'h448, 0, 1, 1, 26'h1), o_idle(1, 0));     // hc=2
    add("wb0_wait",  i_mem(32'h448, 26'h1, 32'hAAAA_0000, 1, 0), o_wr(32'h48, 32'hAAAA_0000, 1, 0, 0));
    add("wb0_done",  i_mem(32'h448, 26'h1, 32'hAAAA_0000, 0, 0), o_wr(32'h48, 32'hAAAA_0000, 1, 0, 0));
    add("wb1_done",  i_mem(32'h448, 26'h1, 32'hAAAA_0004, 0, 0), o_wr(32'h4C, 32'hAAAA_0004, 1, 1, 0));
    add("ld0_conf",  i_mem(32'h448, 26'h1, 32'h0, 0, 0), o_rd(32'h448, 1, 0, 1, 0));
    add("ld1_conf",  i_mem(32'h448, 26'h1, 32'h0, 0, 0), o_rd(32'h44C, 1, 1, 1, 1));
    add("wr_retry",  i_cpu(0, 0, 1, 32'h448, 1, 1, 0, 26'h11), o_hit(1, 0, 1));  // hc=3
    // halt together with a read miss: flush wins, counter unchanged
    add("halt_miss", i_cpu(1, 1, 0, 32'h48, 0, 0, 0, 26'h0), o_idle(1, 0));
    for (int k = 0; k < 8; k++) begin
      logic [2:0]  kx;
      logic [25:0] t;
      logic [31:0] base;
      kx   = 3'(k);
      t    = (k == 0) ? 26'h5 : 26'h3FF_FFFF;
      base = (k == 0) ? 32'h140 : 32'hFFFF_FFF8;
      if (k == 0 || k == 7) begin
        add("fl_chk_dirty", i_fl(1, 1, t), o_idle(kx, 0));
        add("fl_wb0", i_mem(32'h48, t, 32'h1000 + k, 0, 1), o_wr(base, 32'h1000 + k, kx, 0, 0));
        if (k == 7)
          add("fl_wb1_wait", i_mem(32'h48, t, 32'h2000 + k, 1, 1), o_wr(base + 4, 32'h2000 + k, kx, 1, 0));
        add("fl_wb1", i_mem(32'h48, t, 32'h2000 + k, 0, 1), o_wr(base + 4, 32'h2000 + k, kx, 1, 1));
      end else if (k == 3) begin
        add("fl_chk_invalid", i_fl(0, 1, 26'h7), o_idle(kx, 0));
      end else begin
        add("fl_chk_clean", i_fl(1, 0, 26'h7), o_idle(kx, 0));
      end
      add("fl_next", i_fl(1, 1, 26'h7), o_idle(kx, 0));
    end
    add("cnt_wait",  i_mem(32'h48, 26'h0, 32'h0, 1, 1), o_wr(32'h3100, 32'd3, 1, 0, 0));
    add("cnt_done",  i_mem(32'h48, 26'h0, 32'h0, 0, 1), o_wr(32'h3100, 32'd3, 1, 0, 0));
    add("done_hold", i_cpu(0, 1, 0, 32'h48, 1, 1, 0, 26'h1), o_done(1, 0));
    add("done_hold", i_cpu(0, 1, 1, 32'h4C, 1, 1, 0, 26'h1), o_done(1, 1));
    // reset out of DONE, then reset in the middle of a writeback
    add("rst_done",  i_rst(0), '0);
    add("wr_miss2",  i_cpu(0, 0, 1, 32'h448, 0, 1, 1, 26'h1), o_idle(1, 0));    // hc=-1
    add("wb0_2",     i_mem(32'h448, 26'h1, 32'h55, 0, 0), o_wr(32'h48, 32'h55, 1, 0, 0));
    add("wb1_stall", i_mem(32'h448, 26'h1, 32'h66, 1, 0), o_wr(32'h4C, 32'h66, 1, 1, 0));
    add("rst_wb1",   i_rst(1), '0);                                              // hc=0
    add("after_rst", i_mem(32'h448, 26'h1, 32'h66, 1, 0), o_idle(1, 0));
    // one miss from zero must wrap the counter to all-ones
    add("miss_wrap", i_cpu(0, 1, 0, 32'h48, 0, 0, 0, 26'h0), o_idle(1, 0));     // hc=-1
    add("ld0_w",     i_mem(32'h48, 26'h0, 32'h0, 0, 0), o_rd(32'h48, 1, 0, 1, 0));
    add("ld1_w",     i_mem(32'h48, 26'h0, 32'h0, 0, 0), o_rd(32'h4C, 1, 1, 1, 1));
    add("halt2",     i_cpu(1, 0, 0, 32'h48, 0, 0, 0, 26'h0), o_idle(1, 0));
    for (int k = 0; k < 8; k++) begin
      add("fl2_chk",  i_fl(0, 0, 26'h0), o_idle(3'(k), 0));
      add("fl2_next", i_fl(0, 0, 26'h0), o_idle(3'(k), 0));
    end
    add("cnt2",      i_mem(32'h48, 26'h0, 32'h0, 0, 1), o_wr(32'h3100, 32'hFFFF_FFFF, 1, 0, 0));
    add("done2",     i_cpu(0, 0, 0, 32'h48, 0, 0, 0, 26'h0), o_done(1, 0));
  endtask

  initial begin
    RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0;
    arr_hit = 1'b0; arr_valid = 1'b0; arr_dirty = 1'b0; arr_tag = '0;
    arr_word = '0; dwait = 1'b0;
    build();
    @(negedge CLK);
    drive(i_rst(1));
    #2;
    if (RST !== 1'b1 || flushed !== 1'b0 || dhit !== 1'b0 || dREN !== 1'b0 || dWEN !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: dhit=%b dREN=%b dWEN=%b flushed=%b", dhit, dREN, dWEN, flushed);
    end
    chk("reset_state", -1, '0);
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge CLK);
      drive(tbl[k].i);
      #2;
      chk(tbl[k].name, k, tbl[k].o);
    end
    @(negedge CLK);
    drive(iv(0, 0, 0, 0, 32'h48, 0, 0, 0, 26'h0, 32'h0, 0));
    #2;
    chk("done_sticky_wait_expired", tbl.size(), o_done(1, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
